// File: rtl/mem_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the shared
// single-port synchronous memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port (index 0, read-only)
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    // MIPS data port (index 1)
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    // Loader/debug port (index 2)
    logic              x_req;
    logic              x_we;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_wdata;
    logic [DATA_W-1:0] x_rdata;
    logic              x_ack;

    // Shared memory port
    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requester/memory side of the bundle
    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ack,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack,
        output x_req, x_we, x_addr, x_wdata,
        input  x_rdata, x_ack,
        input  mem_ce, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    // Arbiter side of the bundle
    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ack,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack,
        input  x_req, x_we, x_addr, x_wdata,
        output x_rdata, x_ack,
        output mem_ce, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one single-port synchronous memory between
// instruction fetch (0), data (1) and loader/debug (2) requesters.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_arbiter_if.slave bus,
    output logic       busy,
    output logic [1:0] gnt_id
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state, state_next;
    logic [1:0]        last_gnt;
    logic              cur_we;
    logic [2:0]        req_vec, elig;
    logic [1:0]        c0, c1, c2;
    logic              grant;
    logic [1:0]        win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [2:0]        ack_q;
    logic [2:0]        rd_sel;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q, x_rdata_q;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Next state, eligibility and round-robin winner selection
    always_comb begin
        req_vec    = {bus.x_req, bus.d_req, bus.i_req};
        elig       = req_vec & ((state == RESP) ? ~(3'b001 << gnt_id) : 3'b111);
        c0         = rr_next(last_gnt);
        c1         = rr_next(c0);
        c2         = rr_next(c1);
        grant      = 1'b0;
        win        = 2'd0;
        state_next = state;
        if (state == IDLE || state == RESP) begin
            if (elig[c0]) begin
                grant = 1'b1;
                win   = c0;
            end else if (elig[c1]) begin
                grant = 1'b1;
                win   = c1;
            end else if (elig[c2]) begin
                grant = 1'b1;
                win   = c2;
            end
        end
        case (win)
            2'd1: begin
                win_we    = bus.d_we;
                win_addr  = bus.d_addr;
                win_wdata = bus.d_wdata;
            end
            2'd2: begin
                win_we    = bus.x_we;
                win_addr  = bus.x_addr;
                win_wdata = bus.x_wdata;
            end
            default: begin
                win_we    = 1'b0;
                win_addr  = bus.i_addr;
                win_wdata = '0;
            end
        endcase
        case (state)
            IDLE:    state_next = grant ? ISSUE : IDLE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = grant ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, grant bookkeeping and memory command registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            last_gnt      <= 2'd2;
            gnt_id        <= '0;
            cur_we        <= 1'b0;
            busy          <= 1'b0;
            bus.mem_ce    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != IDLE);
            bus.mem_ce <= grant;
            bus.mem_we <= grant & win_we;
            if (grant) begin
                bus.mem_addr  <= win_addr;
                bus.mem_wdata <= win_wdata;
                last_gnt      <= win;
                gnt_id        <= win;
                cur_we        <= win_we;
            end else if (state_next == IDLE) begin
                gnt_id <= '0;
            end
        end
    end

    // Acknowledge pulse and per-port read-data capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_q     <= '0;
            rd_sel    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            x_rdata_q <= '0;
        end else begin
            ack_q  <= (state == ISSUE) ? (3'b001 << gnt_id) : 3'b000;
            rd_sel <= (state == ISSUE && !cur_we) ? (3'b001 << gnt_id) : 3'b000;
            if (rd_sel[0]) i_rdata_q <= bus.mem_rdata;
            if (rd_sel[1]) d_rdata_q <= bus.mem_rdata;
            if (rd_sel[2]) x_rdata_q <= bus.mem_rdata;
        end
    end

    // The memory only presents read data during RESP, so the acked port sees
    // mem_rdata directly in that cycle and its held copy afterwards.
    assign bus.i_ack   = ack_q[0];
    assign bus.d_ack   = ack_q[1];
    assign bus.x_ack   = ack_q[2];
    assign bus.i_rdata = rd_sel[0] ? bus.mem_rdata : i_rdata_q;
    assign bus.d_rdata = rd_sel[1] ? bus.mem_rdata : d_rdata_q;
    assign bus.x_rdata = rd_sel[2] ? bus.mem_rdata : x_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural
// single-port synchronous memory behind it.
module tb_mem_arbiter;
    logic       clk;
    logic       rst;
    logic       busy;
    logic [1:0] gnt_id;
    int         total;
    int         passed;

    logic [31:0] mem [0:255];

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy   (busy),
        .gnt_id (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after the access
    always @(posedge clk) begin
        if (bus.mem_ce) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] port_rdata(input int unsigned p);
        case (p)
            0:       return bus.i_rdata;
            1:       return bus.d_rdata;
            default: return bus.x_rdata;
        endcase
    endfunction

    function automatic logic [31:0] acks();
        return 32'({bus.x_ack, bus.d_ack, bus.i_ack});
    endfunction

    initial begin
        logic [31:0] rr_data [3];
        total   = 0;
        passed  = 0;
        rr_data[0] = 32'h1111_1111;
        rr_data[1] = 32'h2222_2222;
        rr_data[2] = 32'h3333_3333;
        for (int unsigned a = 0; a < 256; a++) mem[a] = '0;
        mem[1]  = 32'h1111_1111;   // 0x04
        mem[2]  = 32'h2222_2222;   // 0x08
        mem[3]  = 32'h3333_3333;   // 0x0C
        mem[5]  = 32'h55AA_55AA;   // 0x14
        mem[8]  = 32'h1234_5678;   // 0x20
        mem[12] = 32'hCAFE_F00D;   // 0x30

        // Reset held with every requester active
        rst         = 1'b0;
        bus.i_req   = 1'b1;  bus.i_addr  = 32'h04;
        bus.d_req   = 1'b1;  bus.d_we    = 1'b0;  bus.d_addr = 32'h08;  bus.d_wdata = '0;
        bus.x_req   = 1'b1;  bus.x_we    = 1'b0;  bus.x_addr = 32'h0C;  bus.x_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_ce",    32'(bus.mem_ce), 32'd0);
        check("rst_mem_we",    32'(bus.mem_we), 32'd0);
        check("rst_mem_addr",  bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_acks",      acks(), 32'd0);
        check("rst_i_rdata",   bus.i_rdata, 32'd0);
        check("rst_d_rdata",   bus.d_rdata, 32'd0);
        check("rst_x_rdata",   bus.x_rdata, 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_gnt",       32'(gnt_id), 32'd0);
        rst = 1'b1;

        // Round-robin with all three requesting: 0,1,2,0,1,2, ack every 2 cycles
        for (int unsigned k = 0; k < 6; k++) begin
            int unsigned p;
            p = k % 3;
            @(negedge clk);
            check("rr_issue_gnt",  32'(gnt_id), 32'(p));
            check("rr_issue_ce",   32'(bus.mem_ce), 32'd1);
            check("rr_issue_addr", bus.mem_addr, 32'(4 * (p + 1)));
            check("rr_issue_acks", acks(), 32'd0);
            check("rr_issue_busy", 32'(busy), 32'd1);
            @(negedge clk);
            check("rr_resp_acks",  acks(), 32'(1 << p));
            check("rr_resp_rdata", port_rdata(p), rr_data[p]);
            check("rr_resp_ce",    32'(bus.mem_ce), 32'd0);
            if (k == 5) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
                bus.x_req = 1'b0;
            end
        end
        @(negedge clk);
        check("rr_idle_busy", 32'(busy), 32'd0);
        check("rr_idle_gnt",  32'(gnt_id), 32'd0);

        // Data write then read of the same word
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("wr_issue_we",    32'(bus.mem_we), 32'd1);
        check("wr_issue_addr",  bus.mem_addr, 32'h10);
        check("wr_issue_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("wr_issue_gnt",   32'(gnt_id), 32'd1);
        @(negedge clk);
        check("wr_resp_ack",    acks(), 32'b010);
        check("wr_resp_rdata",  bus.d_rdata, 32'h2222_2222);
        bus.d_we = 1'b0;
        @(negedge clk);
        check("wr_then_idle",   32'(busy), 32'd0);
        @(negedge clk);
        check("rd_issue_we",    32'(bus.mem_we), 32'd0);
        check("rd_issue_ce",    32'(bus.mem_ce), 32'd1);
        @(negedge clk);
        check("rd_resp_ack",    acks(), 32'b010);
        check("rd_resp_rdata",  bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        @(negedge clk);
        check("rd_idle_busy",   32'(busy), 32'd0);

        // Fetch-only request held through its ack, dropped the cycle after
        bus.i_req = 1'b1; bus.i_addr = 32'h14;
        @(negedge clk);
        check("ov_issue_gnt",  32'(gnt_id), 32'd0);
        check("ov_issue_ce",   32'(bus.mem_ce), 32'd1);
        @(negedge clk);
        check("ov_resp_ack",   acks(), 32'b001);
        check("ov_resp_rdata", bus.i_rdata, 32'h55AA_55AA);
        @(negedge clk);
        check("ov_after_ce",   32'(bus.mem_ce), 32'd0);
        check("ov_after_busy", 32'(busy), 32'd0);
        bus.i_req = 1'b0;
        @(negedge clk);
        check("ov_idle_ce",    32'(bus.mem_ce), 32'd0);
        check("ov_idle_acks",  acks(), 32'd0);

        // Loader request pulsed only during a data ISSUE is withdrawn
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
        @(negedge clk);
        check("wd_issue_gnt",  32'(gnt_id), 32'd1);
        bus.x_req = 1'b1; bus.x_addr = 32'h0C;
        @(negedge clk);
        bus.x_req = 1'b0;
        bus.d_req = 1'b0;
        check("wd_resp_ack",   acks(), 32'b010);
        check("wd_resp_rdata", bus.d_rdata, 32'h1234_5678);
        @(negedge clk);
        check("wd_no_x_ce",    32'(bus.mem_ce), 32'd0);
        check("wd_no_x_busy",  32'(busy), 32'd0);
        @(negedge clk);
        check("wd_no_x_ack",   acks(), 32'd0);

        // Read-data isolation: fetch result does not disturb the data port
        bus.i_req = 1'b1; bus.i_addr = 32'h30;
        @(negedge clk);
        @(negedge clk);
        check("iso_resp_ack",  acks(), 32'b001);
        check("iso_i_rdata",   bus.i_rdata, 32'hCAFE_F00D);
        check("iso_d_rdata",   bus.d_rdata, 32'h1234_5678);
        bus.i_req = 1'b0;
        @(negedge clk);
        check("iso_i_hold",    bus.i_rdata, 32'hCAFE_F00D);
        check("iso_d_hold",    bus.d_rdata, 32'h1234_5678);

        // Reset during a fetch ISSUE aborts it and restores last_gnt=2
        bus.i_req = 1'b1; bus.i_addr = 32'h04;
        @(negedge clk);
        check("ab_issue_ce",   32'(bus.mem_ce), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("ab_acks",       acks(), 32'd0);
        check("ab_busy",       32'(busy), 32'd0);
        check("ab_ce",         32'(bus.mem_ce), 32'd0);
        check("ab_i_rdata",    bus.i_rdata, 32'd0);
        rst = 1'b1;
        bus.d_req = 1'b1; bus.d_addr = 32'h08;
        bus.x_req = 1'b1; bus.x_addr = 32'h0C;
        @(negedge clk);
        check("ab_regrant_gnt", 32'(gnt_id), 32'd0);
        check("ab_regrant_ack", acks(), 32'd0);
        @(negedge clk);
        check("ab_regrant_resp",  acks(), 32'b001);
        check("ab_regrant_rdata", bus.i_rdata, 32'h1111_1111);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.x_req = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
